// File: rtl/dm_write_streamer_pkg.sv
// dm_write_streamer_pkg: shared state encoding, default widths and write latency.
// Rev 1.0
`default_nettype none

package dm_write_streamer_pkg;

  localparam int DEF_AW         = 8;
  localparam int DEF_DW         = 8;
  localparam int DEF_LW         = 8;
  localparam int MEM_WR_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dm_write_streamer_wr_ptr.sv
// wr_ptr: base register plus walking write pointer (load, rewind, increment).
// Rev 1.0
`default_nettype none

module wr_ptr
  import dm_write_streamer_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          rewind_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] base_q;
  logic [AW-1:0] ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      ptr_q  <= '0;
    end else begin
      if (load_i) base_q <= load_val_i;
      // Rewind wins so a new transfer always starts exactly at base.
      if (rewind_i)   ptr_q <= base_q;
      else if (inc_i) ptr_q <= ptr_q + AW'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/dm_write_streamer.sv
// dm_write_streamer: streams valid/ready beats into consecutive data-memory addresses.
// Rev 1.0
`default_nettype none

module dm_write_streamer
  import dm_write_streamer_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
) (
  input  logic          Clk_i,
  input  logic          RSTn_i,
  input  logic          Wen_i,
  input  logic          LenWen_i,
  input  logic [7:0]    BusOut_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  input  logic          mem_stall_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [LW-1:0] count_o
);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [LW-1:0] count_q, count_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [AW-1:0] bus_base;
  logic [LW-1:0] bus_len;
  logic [AW-1:0] ptr;
  logic          is_idle;
  logic          accept;
  logic          rewind;

  // Narrow or zero-extend the 8-bit bus to each register width.
  always_comb begin
    bus_base = '0;
    bus_len  = '0;
    for (int i = 0; i < AW && i < 8; i++) bus_base[i] = BusOut_i[i];
    for (int i = 0; i < LW && i < 8; i++) bus_len[i]  = BusOut_i[i];
  end

  assign is_idle    = (state_q == ST_IDLE);
  assign in_ready_o = (state_q == ST_RUN) && !mem_stall_i && !abort_i;
  assign accept     = in_ready_o && in_valid_i;
  assign rewind     = is_idle && start_i && (len_q != '0);

  wr_ptr #(.AW(AW)) u_wr_ptr (
    .clk_i      (Clk_i),
    .rst_ni     (RSTn_i),
    .load_i     (is_idle && Wen_i),
    .load_val_i (bus_base),
    .rewind_i   (rewind),
    .inc_i      (accept),
    .ptr_o      (ptr)
  );

  always_ff @(posedge Clk_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      remain_q    <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      remain_q    <= remain_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    remain_d    = remain_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (LenWen_i) len_d = bus_len;
        if (start_i) begin
          count_d = '0;
          if (len_q != '0) begin
            state_d  = ST_RUN;
            remain_d = len_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr;
          mem_wdata_d = in_data_i;
          remain_d    = remain_q - LW'(1);
          count_d     = count_q + LW'(1);
          if (remain_q == LW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign count_o     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_write_streamer.sv
// tb_dm_write_streamer: per-cycle vector table plus a stalled-stream scoreboard sequence.
// Rev 1.0
`default_nettype none

module tb_dm_write_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wen, lenwen, start, abort, in_valid, mem_stall;
  logic [7:0] bus, in_data;
  logic       in_ready, mem_we, busy, done;
  logic [7:0] mem_addr, mem_wdata, count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_write_streamer #(.AW(8), .DW(8), .LW(8)) dut (
    .Clk_i       (clk),
    .RSTn_i      (rst_n),
    .Wen_i       (wen),
    .LenWen_i    (lenwen),
    .BusOut_i    (bus),
    .start_i     (start),
    .abort_i     (abort),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .mem_stall_i (mem_stall),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count)
  );

  typedef struct {
    string       name;
    logic        rstn, wen, lenwen;
    logic [7:0]  bus;
    logic        start, abort, valid;
    logic [7:0]  data;
    logic        stall;
    logic [27:0] expv; // {in_ready, mem_we, addr, wdata, busy, done, count}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic w, input logic l, input logic [7:0] b,
                     input logic s, input logic a, input logic v, input logic [7:0] d, input logic st,
                     input logic ery, input logic ewe, input logic [7:0] ead, input logic [7:0] ewd,
                     input logic ebs, input logic edn, input logic [7:0] ecn);
    vec_t t;
    t.name = n; t.rstn = r; t.wen = w; t.lenwen = l; t.bus = b; t.start = s; t.abort = a;
    t.valid = v; t.data = d; t.stall = st;
    t.expv = {ery, ewe, ead, ewd, ebs, edn, ecn};
    vecs.push_back(t);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [7:0] pat;
  logic [7:0] wa[8];
  logic [7:0] wd[8];
  int         nw, beat, stall_leak;
  logic       got_done;

  initial begin
    rst_n = 1'b0; wen = 0; lenwen = 0; bus = 0; start = 0; abort = 0;
    in_valid = 0; in_data = 0; mem_stall = 0;

    //     name      rst wen len bus    st ab v  data   stl | rdy we addr   wdata  bsy dn cnt
    add("reset",     0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("ld_base",   1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("ld_len",    1, 0, 1, 8'h03, 0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("start",     1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("a_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'hA1, 0,   1, 0, 8'h00, 8'h00, 1, 0, 8'h00);
    add("a_b1",      1, 0, 0, 8'h00, 0, 0, 1, 8'hA2, 0,   1, 1, 8'h10, 8'hA1, 1, 0, 8'h01);
    add("a_b2",      1, 0, 0, 8'h00, 0, 0, 1, 8'hA3, 0,   1, 1, 8'h11, 8'hA2, 1, 0, 8'h02);
    add("a_done",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 8'h12, 8'hA3, 0, 1, 8'h03);
    add("a_idle",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h12, 8'hA3, 0, 0, 8'h03);
    add("w_ldbase",  1, 1, 0, 8'hFE, 0, 0, 0, 8'h00, 0,   0, 0, 8'h12, 8'hA3, 0, 0, 8'h03);
    add("w_ldlen",   1, 0, 1, 8'h04, 0, 0, 0, 8'h00, 0,   0, 0, 8'h12, 8'hA3, 0, 0, 8'h03);
    add("w_start",   1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h12, 8'hA3, 0, 0, 8'h03);
    add("w_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'h01, 0,   1, 0, 8'h12, 8'hA3, 1, 0, 8'h00);
    add("w_b1",      1, 0, 0, 8'h00, 0, 0, 1, 8'h02, 0,   1, 1, 8'hFE, 8'h01, 1, 0, 8'h01);
    add("w_b2",      1, 0, 0, 8'h00, 0, 0, 1, 8'h03, 0,   1, 1, 8'hFF, 8'h02, 1, 0, 8'h02);
    add("w_b3",      1, 0, 0, 8'h00, 0, 0, 1, 8'h04, 0,   1, 1, 8'h00, 8'h03, 1, 0, 8'h03);
    add("w_done",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 8'h01, 8'h04, 0, 1, 8'h04);
    add("w_idle",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'h04, 0, 0, 8'h04);
    add("s_start",   1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'h04, 0, 0, 8'h04);
    add("s_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'hB1, 0,   1, 0, 8'h01, 8'h04, 1, 0, 8'h00);
    add("s_stall1",  1, 0, 0, 8'h00, 0, 0, 1, 8'hB2, 1,   0, 1, 8'hFE, 8'hB1, 1, 0, 8'h01);
    add("s_stall2",  1, 0, 0, 8'h00, 0, 0, 1, 8'hB2, 1,   0, 0, 8'hFE, 8'hB1, 1, 0, 8'h01);
    add("s_b1",      1, 0, 0, 8'h00, 0, 0, 1, 8'hB2, 0,   1, 0, 8'hFE, 8'hB1, 1, 0, 8'h01);
    add("s_b2",      1, 0, 0, 8'h00, 0, 0, 1, 8'hB3, 0,   1, 1, 8'hFF, 8'hB2, 1, 0, 8'h02);
    add("s_b3",      1, 0, 0, 8'h00, 0, 0, 1, 8'hB4, 0,   1, 1, 8'h00, 8'hB3, 1, 0, 8'h03);
    add("s_done",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 8'h01, 8'hB4, 0, 1, 8'h04);
    add("s_idle",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h04);
    add("z_ldlen",   1, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h04);
    add("z_start",   1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h04);
    add("z_done",    1, 0, 0, 8'h00, 0, 0, 1, 8'hCC, 0,   0, 0, 8'h01, 8'hB4, 0, 1, 8'h00);
    add("z_idle",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h00);
    add("x_ldbase",  1, 1, 0, 8'h40, 0, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h00);
    add("x_ldlen",   1, 0, 1, 8'h05, 0, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h00);
    add("x_start",   1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h01, 8'hB4, 0, 0, 8'h00);
    add("x_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'hD1, 0,   1, 0, 8'h01, 8'hB4, 1, 0, 8'h00);
    add("x_b1",      1, 0, 0, 8'h00, 0, 0, 1, 8'hD2, 0,   1, 1, 8'h40, 8'hD1, 1, 0, 8'h01);
    add("x_abort",   1, 0, 0, 8'h00, 0, 1, 1, 8'hD3, 0,   0, 1, 8'h41, 8'hD2, 1, 0, 8'h02);
    add("x_idle",    1, 0, 0, 8'h00, 0, 0, 1, 8'hD3, 0,   0, 0, 8'h41, 8'hD2, 0, 0, 8'h02);
    add("r_start",   1, 0, 0, 8'h00, 1, 1, 1, 8'hE1, 0,   0, 0, 8'h41, 8'hD2, 0, 0, 8'h02);
    add("r_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'hE1, 0,   1, 0, 8'h41, 8'hD2, 1, 0, 8'h00);
    add("r_b1_wen",  1, 1, 0, 8'h55, 0, 0, 1, 8'hE2, 0,   1, 1, 8'h40, 8'hE1, 1, 0, 8'h01);
    add("r_b2",      1, 0, 0, 8'h00, 0, 0, 1, 8'hE3, 0,   1, 1, 8'h41, 8'hE2, 1, 0, 8'h02);
    add("r_b3",      1, 0, 0, 8'h00, 0, 0, 1, 8'hE4, 0,   1, 1, 8'h42, 8'hE3, 1, 0, 8'h03);
    add("r_b4",      1, 0, 0, 8'h00, 0, 0, 1, 8'hE5, 0,   1, 1, 8'h43, 8'hE4, 1, 0, 8'h04);
    add("r_done",    1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 1, 8'h44, 8'hE5, 0, 1, 8'h05);
    add("r_idle",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h44, 8'hE5, 0, 0, 8'h05);
    add("o_start",   1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h44, 8'hE5, 0, 0, 8'h05);
    add("o_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'hF1, 0,   1, 0, 8'h44, 8'hE5, 1, 0, 8'h00);
    add("o_oldbase", 1, 0, 0, 8'h00, 0, 0, 1, 8'hF2, 0,   1, 1, 8'h40, 8'hF1, 1, 0, 8'h01);
    add("rst_mid",   0, 0, 0, 8'h00, 0, 0, 1, 8'hF3, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("rst_rel",   1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("p_start0",  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("p_len0",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 1, 8'h00);
    add("p_ldlen1",  1, 0, 1, 8'h01, 0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("p_start1",  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add("p_b0",      1, 0, 0, 8'h00, 0, 0, 1, 8'h77, 0,   1, 0, 8'h00, 8'h00, 1, 0, 8'h00);
    add("p_base0",   1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 8'h00, 8'h77, 0, 1, 8'h01);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst_n = vecs[i].rstn; wen = vecs[i].wen; lenwen = vecs[i].lenwen; bus = vecs[i].bus;
      start = vecs[i].start; abort = vecs[i].abort; in_valid = vecs[i].valid;
      in_data = vecs[i].data; mem_stall = vecs[i].stall;
      @(negedge clk);
      check(vecs[i].name, {4'h0, in_ready, mem_we, mem_addr, mem_wdata, busy, done, count},
            {4'h0, vecs[i].expv});
    end

    // Irregular stall pattern with in_valid held: writes must stay contiguous and complete.
    pat = 8'b1001_0110;
    nw = 0; beat = 0; stall_leak = 0; got_done = 1'b0;
    @(posedge clk); #1;
    wen = 1; lenwen = 0; bus = 8'h80; start = 0; abort = 0; in_valid = 0; mem_stall = 0;
    @(posedge clk); #1;
    wen = 0; lenwen = 1; bus = 8'h03;
    @(posedge clk); #1;
    lenwen = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 40; k++) begin
      mem_stall = pat[k % 8];
      in_valid  = (beat < 3);
      in_data   = 8'(8'h90 + beat);
      @(negedge clk);
      if (mem_stall && in_ready) stall_leak++;
      if (mem_we && nw < 8) begin
        wa[nw] = mem_addr;
        wd[nw] = mem_wdata;
        nw++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (in_ready && in_valid) beat++;
      @(posedge clk); #1;
    end
    in_valid = 0; mem_stall = 0;
    check("h_done_seen", 32'(got_done), 32'd1);
    check("h_ready_under_stall", 32'(stall_leak), 32'd0);
    check("h_write_count", 32'(nw), 32'd3);
    check("h_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("h_addr%0d", i), 32'(wa[i]), 32'(8'h80 + i));
      check($sformatf("h_data%0d", i), 32'(wd[i]), 32'(8'h90 + i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
